// File: rtl/high_score_keeper_if.sv
// Session/result bus between the login/game stages and the high-score keeper.
interface high_score_keeper_if #(
    parameter int SCORE_W = 8
);
    logic               logged_in;
    logic [2:0]         user_id;
    logic               game_done;
    logic [SCORE_W-1:0] final_score;
    logic [SCORE_W-1:0] high_score;
    logic [3:0]         games_played;
    logic               ready;
    logic               new_record;

    modport master (
        output logged_in, user_id, game_done, final_score,
        input  high_score, games_played, ready, new_record
    );

    modport slave (
        input  logged_in, user_id, game_done, final_score,
        output high_score, games_played, ready, new_record
    );
endinterface

// File: rtl/high_score_keeper.sv
// Per-user best score and game count table with lookup latency and a timed
// new-record celebration pulse.
module high_score_keeper #(
    parameter int SCORE_W          = 8,
    parameter int NUM_USERS        = 6,
    parameter int CELEBRATE_CYCLES = 100
) (
    input logic               clk,
    input logic               rst,
    high_score_keeper_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, RD_WAIT1, RD_WAIT2, READY, COMPARE, WRITE, CELEBRATE
    } state_t;

    localparam int               CNT_W    = (CELEBRATE_CYCLES > 1) ? $clog2(CELEBRATE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELEBRATE_CYCLES - 1);
    localparam logic [3:0]       USERS    = 4'(NUM_USERS);

    state_t             state;
    logic [SCORE_W-1:0] tbl_score [NUM_USERS];
    logic [3:0]         tbl_games [NUM_USERS];
    logic [2:0]         uid;
    logic [SCORE_W-1:0] latched;
    logic [SCORE_W-1:0] high_score_q;
    logic [3:0]         games_q;
    logic               ready_q;
    logic               new_record_q;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         games_inc;

    always_comb begin
        games_inc = (tbl_games[uid] == 4'hF) ? 4'hF : tbl_games[uid] + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            for (int unsigned i = 0; i < NUM_USERS; i++) begin
                tbl_score[i[2:0]] <= '0;
                tbl_games[i[2:0]] <= '0;
            end
            uid          <= '0;
            latched      <= '0;
            high_score_q <= '0;
            games_q      <= '0;
            ready_q      <= 1'b0;
            new_record_q <= 1'b0;
            cnt          <= '0;
        end else if (!bus.logged_in && state != WRITE) begin
            state        <= IDLE;
            ready_q      <= 1'b0;
            new_record_q <= 1'b0;
            high_score_q <= '0;
            games_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.logged_in && {1'b0, bus.user_id} < USERS) begin
                        uid   <= bus.user_id;
                        state <= RD_WAIT1;
                    end
                end
                RD_WAIT1: state <= RD_WAIT2;
                RD_WAIT2: begin
                    high_score_q <= tbl_score[uid];
                    games_q      <= tbl_games[uid];
                    ready_q      <= 1'b1;
                    state        <= READY;
                end
                READY: begin
                    if (bus.game_done) begin
                        latched <= bus.final_score;
                        ready_q <= 1'b0;
                        state   <= COMPARE;
                    end
                end
                COMPARE: begin
                    tbl_games[uid] <= games_inc;
                    games_q        <= games_inc;
                    if (latched > tbl_score[uid]) begin
                        state <= WRITE;
                    end else begin
                        ready_q <= 1'b1;
                        state   <= READY;
                    end
                end
                WRITE: begin
                    // The table write always lands; a logout seen here only skips the celebration.
                    tbl_score[uid] <= latched;
                    if (!bus.logged_in) begin
                        state        <= IDLE;
                        ready_q      <= 1'b0;
                        new_record_q <= 1'b0;
                        high_score_q <= '0;
                        games_q      <= '0;
                    end else begin
                        high_score_q <= latched;
                        new_record_q <= 1'b1;
                        cnt          <= '0;
                        state        <= CELEBRATE;
                    end
                end
                CELEBRATE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        new_record_q <= 1'b0;
                        ready_q      <= 1'b1;
                        state        <= READY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.high_score   = high_score_q;
    assign bus.games_played = games_q;
    assign bus.ready        = ready_q;
    assign bus.new_record   = new_record_q;
endmodule
